// File: rtl/ow_slot_engine.sv
// Multi-channel 1-Wire master slot engine: reset/presence, write-bit and read-bit
// slots on one of CH open-drain lines, timings scaled by CLK_PER_US.

module ow_lane #(
  parameter int CHW = 2,
  parameter int IDX = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           dq_in,
  input  logic           drive,
  input  logic [CHW-1:0] ch_sel,
  output logic           dq_sync,
  output logic           dq_ena
);
  logic meta;

  // Idle bus is high, so the synchroniser resets to 1 to avoid a false presence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= 1'b1;
      dq_sync <= 1'b1;
    end else begin
      meta    <= dq_in;
      dq_sync <= meta;
    end
  end

  assign dq_ena = drive && (ch_sel == CHW'(IDX));
endmodule

module ow_slot_engine #(
  parameter int CH         = 4,
  parameter int CLK_PER_US = 8,
  parameter int T_RSTL     = 480,
  parameter int T_PDW      = 70,
  parameter int T_RSTH     = 410,
  parameter int T_SLOT     = 65,
  parameter int T_LOW1     = 6,
  parameter int T_LOW0     = 60,
  parameter int T_RDS      = 15,
  parameter int T_REC      = 5,
  localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [CHW-1:0] cmd_ch,
  input  logic           cmd_wbit,
  output logic           rsp_valid,
  output logic           rsp_bit,
  output logic           rsp_err,
  input  logic [CH-1:0]  dq_in,
  output logic [CH-1:0]  dq_out,
  output logic [CH-1:0]  dq_ena
);
  localparam logic [15:0] C_RSTL = 16'(T_RSTL * CLK_PER_US);
  localparam logic [15:0] C_PDW  = 16'(T_PDW  * CLK_PER_US);
  localparam logic [15:0] C_RSTH = 16'(T_RSTH * CLK_PER_US);
  localparam logic [15:0] C_SLOT = 16'(T_SLOT * CLK_PER_US);
  localparam logic [15:0] C_LOW1 = 16'(T_LOW1 * CLK_PER_US);
  localparam logic [15:0] C_LOW0 = 16'(T_LOW0 * CLK_PER_US);
  localparam logic [15:0] C_RDS  = 16'(T_RDS  * CLK_PER_US);
  localparam logic [15:0] C_REC  = 16'(T_REC  * CLK_PER_US);

  if (!(CH >= 1 && CH <= 16 && CLK_PER_US >= 1 && T_LOW1 >= 1 && T_REC >= 1 &&
        T_LOW1 < T_RDS && T_RDS < T_SLOT && T_LOW0 < T_SLOT && T_PDW >= 1 &&
        T_PDW < T_RSTH && T_RSTL >= 1 && T_RSTL * CLK_PER_US < 65536 &&
        T_RSTH * CLK_PER_US < 65536)) begin : g_param_check
    $error("ow_slot_engine: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, RST_LO, RST_HI, SLOT, REC, RESP} state_t;

  state_t         state, state_d;
  logic [15:0]    cnt;
  logic           cnt_clr, accept, illegal, drive;
  logic [CHW-1:0] ch_q;
  logic           rd_q, wbit_q;
  logic [CH-1:0]  dq_sync;
  logic [15:0]    low_len;

  assign illegal = (cmd_op == 2'b11) || (int'(cmd_ch) >= CH);
  assign low_len = (rd_q || wbit_q) ? C_LOW1 : C_LOW0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    cnt_clr   = 1'b0;
    accept    = 1'b0;
    drive     = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          if (illegal)               state_d = RESP;
          else if (cmd_op == 2'b00)  state_d = RST_LO;
          else                       state_d = SLOT;
        end
      end
      RST_LO: begin
        drive = 1'b1;
        if (cnt == C_RSTL - 16'd1) begin
          state_d = RST_HI;
          cnt_clr = 1'b1;
        end
      end
      RST_HI: begin
        if (cnt == C_RSTH - 16'd1) begin
          state_d = RESP;
          cnt_clr = 1'b1;
        end
      end
      SLOT: begin
        drive = (cnt < low_len);
        if (cnt == C_SLOT - 16'd1) begin
          state_d = REC;
          cnt_clr = 1'b1;
        end
      end
      REC: begin
        if (cnt == C_REC - 16'd1) begin
          state_d = RESP;
          cnt_clr = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rsp_bit/rsp_err are preset at acceptance and overwritten at the sample point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      ch_q    <= '0;
      rd_q    <= 1'b0;
      wbit_q  <= 1'b0;
      rsp_bit <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 16'd1;
      if (accept) begin
        ch_q    <= cmd_ch;
        rd_q    <= (cmd_op == 2'b10);
        wbit_q  <= cmd_wbit;
        rsp_bit <= (cmd_op == 2'b01) && !illegal && cmd_wbit;
        rsp_err <= illegal;
      end
      if (state == RST_HI && cnt == C_PDW - 16'd1) begin
        rsp_bit <= ~dq_sync[ch_q];
        rsp_err <= dq_sync[ch_q];
      end
      if (state == SLOT && rd_q && cnt == C_RDS - 16'd1)
        rsp_bit <= dq_sync[ch_q];
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    ow_lane #(.CHW(CHW), .IDX(i)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .dq_in   (dq_in[i]),
      .drive   (drive),
      .ch_sel  (ch_q),
      .dq_sync (dq_sync[i]),
      .dq_ena  (dq_ena[i])
    );
  end

  assign dq_out = '0;
endmodule

// File: doc/ow_slot_engine.md
# ow_slot_engine

Parametrised multi-channel 1-Wire master slot engine. It generates reset/presence, write-bit and read-bit time slots on one of `CH` open-drain DQ lines, with every timing in microseconds scaled by `CLK_PER_US`. It sits between the byte/ROM-command layer and the per-channel `owpad` instances, driving each pad's `dq_out`/`dq_ena` and sampling its `dq_in`.

## Interface
- `CH`, 4: number of DQ channels (1..16).
- `CLK_PER_US`, 8: clock cycles per microsecond (K below).
- `T_RSTL`, 480: reset low time, µs.
- `T_PDW`, 70: presence sample point after release, µs.
- `T_RSTH`, 410: reset high (release) time, µs.
- `T_SLOT`, 65: bit slot length, µs.
- `T_LOW1`, 6: low time for write-1 and read initiation, µs.
- `T_LOW0`, 60: low time for write-0, µs.
- `T_RDS`, 15: read sample point from slot start, µs.
- `T_REC`, 5: recovery after each slot, µs.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  engine idle; command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  00 reset/presence, 01 write bit, 10 read bit, 11 illegal.
- `cmd_ch`  in  max(1,$clog2(CH))  target channel.
- `cmd_wbit`  in  1  bit to write (op 01).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_bit`  out  1  presence (op 00), read bit (op 10), echoed `cmd_wbit` (op 01).
- `rsp_err`  out  1  no presence detected, illegal op, or `cmd_ch >= CH`.
- `dq_in`  in  CH  raw pad inputs (asynchronous).
- `dq_out`  out  CH  tied 0.
- `dq_ena`  out  CH  1 = pull that line low (open drain).

## Operation
- Derived parameters: `dq_in` passes through a 2-flop synchroniser per channel; all "sample" references below use the synchronised value. Timings are in cycles `T_x*K`. The counter is 16 bits. Elaboration-time checks: `T_LOW1 < T_RDS < T_SLOT`, `T_LOW0 < T_SLOT`, `T_PDW < T_RSTH`, `T_RSTL*K < 65536`.
- Command capture: all command fields are registered at acceptance. Later changes on the command inputs have no effect.
- States: IDLE, RST_LO, RST_HI, SLOT, REC, RESP.
- IDLE: `cmd_ready`=1. On accept:
  - Legal command → RST_LO (op 00) or SLOT (op 01/10).
  - Op 11 or `cmd_ch >= CH` → RESP with `rsp_err`=1, `rsp_bit`=0; no line activity.
- RST_LO: `dq_ena[ch]`=1 for T_RSTL·K cycles, then → RST_HI.
- RST_HI: line released for T_RSTH·K cycles.
  - Sample at release cycle T_PDW·K; presence = (sample==0).
  - At end → RESP with `rsp_bit`=presence and `rsp_err`=!presence.
- SLOT: lasts T_SLOT·K cycles.
  - `dq_ena[ch]`=1 for the first T_LOW1·K cycles (write-1, read) or T_LOW0·K cycles (write-0), then released.
  - Read: sample at slot cycle T_RDS·K.
  - → REC.
- REC: line released for T_REC·K cycles, then → RESP.
- RESP: `rsp_valid`=1 for one cycle, `cmd_ready`=0, then → IDLE.
- Channel isolation: at most one `dq_ena` bit is high at any time, and only for the captured channel.
- `dq_out` is constant 0.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `rsp_valid`, `rsp_bit`, `rsp_err`=0.
  - `dq_ena`=0, `dq_out`=0.
  - State IDLE; synchronisers cleared to 1.
- Cycle numbering: acceptance edge = cycle 0; the first driven-low cycle = cycle 1.
- Reset op:
  - Low on cycles 1..T_RSTL·K.
  - Presence sample at cycle T_RSTL·K + T_PDW·K.
  - `rsp_valid` at cycle (T_RSTL+T_RSTH)·K + 1.
- Write/read op:
  - Low on cycles 1..T_LOWx·K.
  - Read sample at cycle T_RDS·K; the synchronised value reflects the raw input 2 cycles earlier.
  - `rsp_valid` at cycle (T_SLOT+T_REC)·K + 1.
- Error response: `rsp_valid` at cycle 1.
- Back-to-back: the earliest next acceptance is the cycle after `rsp_valid`. `cmd_ready` is low from acceptance through RESP.
- `rst` asserted mid-operation: `dq_ena` clears immediately (asynchronous), no response is issued, and the engine returns to IDLE.
- `rst` deasserted: the first acceptance is possible on the next `clk` edge.

## Test plan
Settings: K=1, default timings, CH=4.
- Reset with presence: op 00 on ch 2; slave pulls `dq_in[2]` low on cycles 511..600 → `dq_ena[2]` high on cycles 1..480 only; `rsp_valid` at cycle 891 with `rsp_bit`=1, `rsp_err`=0; `dq_ena[0,1,3]`=0 throughout.
- Reset without presence: op 00 on ch 0; line held high → cycle 891 gives `rsp_bit`=0, `rsp_err`=1.
- Write 0 then write 1 back-to-back on ch 1:
  - Write 0: low on cycles 1..60, `rsp_valid` at cycle 71.
  - Write 1: accepted at cycle 72; low on 73..78; `rsp_valid` at cycle 143; `rsp_bit` echoes 0 then 1.
- Read on ch 3 with slave holding low on cycles 1..40 → `rsp_bit`=0. Line returns high at cycle 7 → `rsp_bit`=1. Both complete at cycle 71.
- `cmd_ch`=5 (≥CH), then op 11 → each gives `rsp_valid` at cycle 1 with `rsp_err`=1 and no `dq_ena` activity.
- `rst` pulsed at cycle 200 of a reset op → `dq_ena` goes 0 within that cycle; no `rsp_valid`; `cmd_ready`=1 after `rst` falls; a new write completes normally.
